// File: rtl/ds1302_serial_engine.sv
// Serial transaction engine for the DS1302 RTC 3-wire bus (CE / SCLK / IO), LSB first.
// Optional macro DS1302_BCD_CHECK_EN adds rd_bcd_err, a BCD sanity flag on each read byte.
module ds1302_serial_engine #(
   parameter int CLK_DIV = 50,
   parameter int CE_GAP  = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_byte,
   input  logic [7:0] wr_data,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       ds1302_ce,
   output logic       ds1302_sclk,
   inout  wire        ds1302_io,
`ifdef DS1302_BCD_CHECK_EN
   output logic       rd_bcd_err,
`endif
   output logic [1:0] dbg_state
);

   // Handshake: a request is taken on any rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE and never during reset, so there is no queuing.

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CE_GAP - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_cnt;
   logic [4:0]  r_pulse;
   logic [15:0] r_tx;
   logic        r_is_read;
   logic [7:0]  r_rx;
   logic        r_io_oe;
   logic        r_io_out;
   logic        r_ce;
   logic        r_sclk;
   logic        r_rd_valid;
   logic [7:0]  r_rd_data;
   logic        w_accept;
   logic        w_io_in;
   logic        w_phase_end;
   logic [4:0]  w_last_pulse;
   logic [3:0]  w_next_bit;
   logic [7:0]  w_rd_byte;

   assign w_accept     = cmd_valid && cmd_ready;
   assign w_io_in      = ds1302_io;
   assign w_phase_end  = (r_cnt == DIV_LAST);
   assign w_last_pulse = r_is_read ? 5'd14 : 5'd15;
   assign w_next_bit   = r_pulse[3:0] + 4'd1;
   assign w_rd_byte    = {w_io_in, r_rx[7:1]};

   assign cmd_ready   = (r_state == S_IDLE) && !rst;
   assign busy        = (r_state != S_IDLE);
   assign ds1302_ce   = r_ce;
   assign ds1302_sclk = r_sclk;
   assign ds1302_io   = r_io_oe ? r_io_out : 1'bz;
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign dbg_state   = r_state;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_SETUP;
         S_SETUP: if (w_phase_end) w_next_state = S_SHIFT;
         S_SHIFT: if (!r_sclk && w_phase_end && (r_pulse == w_last_pulse)) w_next_state = S_GAP;
         S_GAP:   if (r_cnt == GAP_LAST) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_pulse    <= '0;
         r_tx       <= '0;
         r_is_read  <= 1'b0;
         r_rx       <= '0;
         r_io_oe    <= 1'b0;
         r_io_out   <= 1'b0;
         r_ce       <= 1'b0;
         r_sclk     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_accept) begin
                  r_tx      <= {wr_data, cmd_byte};
                  r_is_read <= cmd_byte[0];
                  r_pulse   <= '0;
                  r_ce      <= 1'b1;
                  r_io_oe   <= 1'b1;
                  r_io_out  <= cmd_byte[0];
               end
            end
            S_SETUP: begin
               if (w_phase_end) begin
                  r_cnt  <= '0;
                  r_sclk <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_SHIFT: begin
               if (!w_phase_end) begin
                  r_cnt <= r_cnt + 16'd1;
               end else if (r_sclk) begin
                  // Falling edge number r_pulse+1: present the next bit or let go of the line.
                  r_cnt  <= '0;
                  r_sclk <= 1'b0;
                  if ((r_is_read && r_pulse == 5'd7) || (!r_is_read && r_pulse == 5'd15))
                     r_io_oe <= 1'b0;
                  else if (r_io_oe)
                     r_io_out <= r_tx[w_next_bit];
               end else begin
                  // Last cycle of a low phase: read data bits are sampled here.
                  r_cnt <= '0;
                  if (r_is_read && r_pulse >= 5'd7)
                     r_rx <= w_rd_byte;
                  if (r_pulse == w_last_pulse) begin
                     r_ce <= 1'b0;
                     if (r_is_read) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_rd_byte;
                     end
                  end else begin
                     r_sclk  <= 1'b1;
                     r_pulse <= r_pulse + 5'd1;
                  end
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) r_cnt <= '0;
               else                   r_cnt <= r_cnt + 16'd1;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

`ifdef DS1302_BCD_CHECK_EN
   logic r_bcd_err;
   assign rd_bcd_err = r_bcd_err;

   always_ff @(posedge clk) begin
      if (rst)
         r_bcd_err <= 1'b0;
      else if (r_state == S_SHIFT && !r_sclk && w_phase_end && r_is_read && r_pulse == w_last_pulse)
         r_bcd_err <= (w_rd_byte[7:4] > 4'd9) || (w_rd_byte[3:0] > 4'd9);
   end
`endif

endmodule
